// File: rtl/multi_watchdog.sv
// Bank of independent watchdog timers sharing one free-running prescaler.
// Each channel counts down prescaler ticks from its kicked timeout and latches an expiry flag.
module multi_watchdog #(
  parameter int unsigned CHANNELS         = 4,
  parameter int unsigned PRESCALE_BITS    = 10,
  parameter int unsigned COUNT_BITS       = 8,
  parameter bit          EXPIRED_ON_RESET = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [CHANNELS-1:0]            kick,
  input  logic [CHANNELS-1:0]            enable,
  input  logic [CHANNELS*COUNT_BITS-1:0] timeout,
  output logic [CHANNELS-1:0]            expired,
  output logic [CHANNELS-1:0]            expire_pulse,
  output logic                           any_expired
);

  logic [PRESCALE_BITS-1:0] presc_q, presc_d;
  logic                     tick;

  logic [COUNT_BITS-1:0] cnt_q [CHANNELS];
  logic [COUNT_BITS-1:0] cnt_d [CHANNELS];
  logic [CHANNELS-1:0]   armed_q, armed_d;
  logic [CHANNELS-1:0]   expired_q, expired_d;
  logic [CHANNELS-1:0]   pulse_q, pulse_d;

  assign presc_d = presc_q + PRESCALE_BITS'(1);
  assign tick    = &presc_q;

  // A channel only counts once it has been kicked since reset; an idle
  // post-reset channel with cnt=0 must not spontaneously expire.
  always_comb begin
    armed_d   = armed_q;
    expired_d = expired_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (kick[i]) begin
        cnt_d[i]     = timeout[i*COUNT_BITS +: COUNT_BITS];
        armed_d[i]   = 1'b1;
        expired_d[i] = 1'b0;
      end else if (tick && enable[i] && armed_q[i] && !expired_q[i]) begin
        if (cnt_q[i] > COUNT_BITS'(1)) begin
          cnt_d[i] = cnt_q[i] - COUNT_BITS'(1);
        end else begin
          cnt_d[i]     = '0;
          expired_d[i] = 1'b1;
        end
      end
    end
    pulse_d = expired_d & ~expired_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q   <= '0;
      armed_q   <= '0;
      expired_q <= {CHANNELS{EXPIRED_ON_RESET}};
      pulse_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      presc_q   <= presc_d;
      armed_q   <= armed_d;
      expired_q <= expired_d;
      pulse_q   <= pulse_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign expired      = expired_q;
  assign expire_pulse = pulse_q;
  assign any_expired  = |expired_q;

endmodule

// File: tb/tb_multi_watchdog.sv
// Randomised and directed bench for multi_watchdog (2 channels, tick every 4 cycles).
// A tick-counting reference model predicts every output each cycle.
module tb_multi_watchdog;

  localparam int CH = 2;
  localparam int PB = 2;
  localparam int CB = 4;

  logic          clk;
  logic          reset_n;
  logic [CH-1:0] kick;
  logic [CH-1:0] enable;
  logic [CH*CB-1:0] timeout;
  logic [CH-1:0] expired, expire_pulse;
  logic          any_expired;
  logic [CH-1:0] expired1, expire_pulse1;
  logic          any_expired1;

  int total_cnt = 0;
  int pass_cnt  = 0;

  multi_watchdog #(.CHANNELS(CH), .PRESCALE_BITS(PB), .COUNT_BITS(CB), .EXPIRED_ON_RESET(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .kick(kick), .enable(enable), .timeout(timeout),
    .expired(expired), .expire_pulse(expire_pulse), .any_expired(any_expired)
  );

  multi_watchdog #(.CHANNELS(CH), .PRESCALE_BITS(PB), .COUNT_BITS(CB), .EXPIRED_ON_RESET(1'b1)) dut_eor1 (
    .clk(clk), .reset_n(reset_n), .kick(kick), .enable(enable), .timeout(timeout),
    .expired(expired1), .expire_pulse(expire_pulse1), .any_expired(any_expired1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: cycles since reset, ticks remaining per channel
  int            presc_m;
  int            rem_m [CH];
  bit            run_m [CH];
  logic [CH-1:0] exp_m, pul_m;

  function automatic logic [4:0] model_vec();
    return {exp_m, pul_m, |exp_m};
  endfunction

  task automatic model_reset();
    presc_m = 0;
    exp_m   = '0;
    pul_m   = '0;
    for (int c = 0; c < CH; c++) begin
      rem_m[c] = 0;
      run_m[c] = 1'b0;
    end
  endtask

  // advance model by one edge using current inputs, then wait to the next negedge
  task automatic step();
    bit tk;
    int t;
    tk    = (presc_m == (1 << PB) - 1);
    pul_m = '0;
    for (int c = 0; c < CH; c++) begin
      t = int'(timeout[c*CB +: CB]);
      if (kick[c]) begin
        rem_m[c] = (t == 0) ? 1 : t;
        run_m[c] = 1'b1;
        exp_m[c] = 1'b0;
      end else if (tk && enable[c] && run_m[c] && !exp_m[c]) begin
        rem_m[c]--;
        if (rem_m[c] == 0) begin
          exp_m[c] = 1'b1;
          pul_m[c] = 1'b1;
          run_m[c] = 1'b0;
        end
      end
    end
    presc_m = (presc_m + 1) % (1 << PB);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_to(input int c, input int v);
    timeout[c*CB +: CB] = CB'(v);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    kick    = '0;
    enable  = '0;
    timeout = '0;
    model_reset();
    #12;
    total_cnt++;
    if ({expired, expire_pulse, any_expired} !== 5'b00000)
      $display("FAIL reset_eor0: got %b want %b", {expired, expire_pulse, any_expired}, 5'b00000);
    else pass_cnt++;
    total_cnt++;
    if ({expired1, expire_pulse1, any_expired1} !== 5'b11001)
      $display("FAIL reset_eor1: got %b want %b", {expired1, expire_pulse1, any_expired1}, 5'b11001);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    enable  = 2'b11;
    for (int k = 0; k < 8; k++) begin
      step();
      total_cnt++;
      if ({expired1, expire_pulse1, any_expired1} !== 5'b11001)
        $display("FAIL reset_eor1_hold cyc %0d: got %b want %b", k, {expired1, expire_pulse1, any_expired1}, 5'b11001);
      else pass_cnt++;
      total_cnt++;
      if ({expired, expire_pulse, any_expired} !== model_vec())
        $display("FAIL reset_idle cyc %0d: got %b want %b", k, {expired, expire_pulse, any_expired}, model_vec());
      else pass_cnt++;
    end
  endtask

  task automatic test_basic_expiry();
    int pulses;
    int ticks_seen;
    int rise_tick;
    pulses = 0; ticks_seen = 0; rise_tick = -1;
    enable = 2'b11;
    set_to(0, 3);
    while (presc_m == 3) step();
    kick = 2'b01;
    step();
    kick = 2'b00;
    for (int k = 0; k < 24; k++) begin
      if (presc_m == 3) ticks_seen++;
      step();
      if (expire_pulse[0]) pulses++;
      if (expired[0] && rise_tick < 0) rise_tick = ticks_seen;
      total_cnt++;
      if ({expired, expire_pulse, any_expired} !== model_vec())
        $display("FAIL basic cyc %0d: got %b want %b", k, {expired, expire_pulse, any_expired}, model_vec());
      else pass_cnt++;
    end
    total_cnt++;
    if (pulses !== 1) $display("FAIL basic_pulse_count: got %0d want 1", pulses);
    else pass_cnt++;
    total_cnt++;
    if (rise_tick !== 3) $display("FAIL basic_rise_tick: got %0d want 3", rise_tick);
    else pass_cnt++;
    total_cnt++;
    if (expired[1] !== 1'b0) $display("FAIL basic_ch1_untouched: got %b want 0", expired[1]);
    else pass_cnt++;
  endtask

  task automatic test_keepalive();
    bit rose;
    int after;
    rose = 1'b0;
    after = -1;
    enable = 2'b11;
    set_to(0, 5);
    for (int k = 0; k < 100; k++) begin
      kick = (k % 12 == 0) ? 2'b01 : 2'b00;
      step();
      if (expired[0]) rose = 1'b1;
      total_cnt++;
      if ({expired, expire_pulse, any_expired} !== model_vec())
        $display("FAIL keepalive cyc %0d: got %b want %b", k, {expired, expire_pulse, any_expired}, model_vec());
      else pass_cnt++;
    end
    total_cnt++;
    if (rose !== 1'b0) $display("FAIL keepalive_no_expiry: got %b want 0", rose);
    else pass_cnt++;
    kick = 2'b01;
    step();
    kick = 2'b00;
    for (int k = 0; k < 30; k++) begin
      step();
      if (expire_pulse[0] && after < 0) after = k + 1;
      total_cnt++;
      if ({expired, expire_pulse, any_expired} !== model_vec())
        $display("FAIL keepalive_stop cyc %0d: got %b want %b", k, {expired, expire_pulse, any_expired}, model_vec());
      else pass_cnt++;
    end
    // 5 ticks of 4 cycles: expiry lands 17..20 edges after the kick edge
    total_cnt++;
    if (after < 17 || after > 20) $display("FAIL keepalive_latency: got %0d want 17..20", after);
    else pass_cnt++;
  endtask

  task automatic test_timeout_zero();
    bit found;
    enable = 2'b11;
    set_to(0, 0);
    kick = 2'b01;
    for (int k = 0; k < 10; k++) begin
      step();
      total_cnt++;
      if (expired[0] !== 1'b0 || {expired, expire_pulse, any_expired} !== model_vec())
        $display("FAIL tz_held cyc %0d: got %b want %b", k, {expired, expire_pulse, any_expired}, model_vec());
      else pass_cnt++;
    end
    kick = 2'b00;
    for (int k = 0; k < 6; k++) begin
      step();
      total_cnt++;
      if ({expired, expire_pulse, any_expired} !== model_vec())
        $display("FAIL tz_release cyc %0d: got %b want %b", k, {expired, expire_pulse, any_expired}, model_vec());
      else pass_cnt++;
    end
    set_to(0, 2);
    kick = 2'b01;
    step();
    kick = 2'b00;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (presc_m == 3 && rem_m[0] == 1 && run_m[0] && !exp_m[0]) found = 1'b1;
      else step();
    end
    total_cnt++;
    if (!found) $display("FAIL tz_find_expiry_tick: got 0 want 1");
    else pass_cnt++;
    kick = 2'b01;
    step();
    kick = 2'b00;
    total_cnt++;
    if (expired[0] !== 1'b0 || expire_pulse[0] !== 1'b0)
      $display("FAIL tz_kick_on_expiry: got %b%b want 00", expired[0], expire_pulse[0]);
    else pass_cnt++;
    for (int k = 0; k < 12; k++) begin
      step();
      total_cnt++;
      if ({expired, expire_pulse, any_expired} !== model_vec())
        $display("FAIL tz_after cyc %0d: got %b want %b", k, {expired, expire_pulse, any_expired}, model_vec());
      else pass_cnt++;
    end
  endtask

  task automatic test_enable_mask();
    enable = 2'b11;
    set_to(1, 4);
    kick = 2'b10;
    step();
    kick = 2'b00;
    for (int k = 0; k < 46; k++) begin
      if (k == 3)  enable[1] = 1'b0;
      if (k == 23) begin
        enable[1] = 1'b1;
        set_to(1, 15);
      end
      step();
      total_cnt++;
      if ({expired, expire_pulse, any_expired} !== model_vec())
        $display("FAIL enable_mask cyc %0d: got %b want %b", k, {expired, expire_pulse, any_expired}, model_vec());
      else pass_cnt++;
    end
    total_cnt++;
    if (expired[1] !== 1'b1) $display("FAIL enable_mask_done: got %b want 1", expired[1]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < CH; c++) begin
        kick[c]   = ($urandom_range(0, 15) == 0);
        enable[c] = ($urandom_range(0, 7) != 0);
        set_to(c, int'($urandom_range(0, 6)));
      end
      step();
      total_cnt++;
      if ({expired, expire_pulse, any_expired} !== model_vec())
        $display("FAIL random cyc %0d: got %b want %b", k, {expired, expire_pulse, any_expired}, model_vec());
      else pass_cnt++;
    end
    kick = '0;
  endtask

  task automatic test_async_reset();
    enable = 2'b11;
    set_to(0, 6);
    set_to(1, 3);
    kick = 2'b11;
    step();
    kick = 2'b00;
    for (int k = 0; k < 7; k++) step();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    total_cnt++;
    if ({expired, expire_pulse, any_expired} !== 5'b00000)
      $display("FAIL async_reset_eor0: got %b want %b", {expired, expire_pulse, any_expired}, 5'b00000);
    else pass_cnt++;
    total_cnt++;
    if ({expired1, expire_pulse1, any_expired1} !== 5'b11001)
      $display("FAIL async_reset_eor1: got %b want %b", {expired1, expire_pulse1, any_expired1}, 5'b11001);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      total_cnt++;
      if ({expired, expire_pulse, any_expired} !== 5'b00000)
        $display("FAIL async_reset_idle cyc %0d: got %b want %b", k, {expired, expire_pulse, any_expired}, 5'b00000);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_expiry();
    test_keepalive();
    test_timeout_zero();
    test_enable_mask();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time budget exceeded");
    $fatal(1);
  end

endmodule

// File: doc/multi_watchdog.md
MULTI_WATCHDOG -- requirements
Module: multi_watchdog

Interface
REQ-001: Parameter CHANNELS, default 4, number of independent watchdog channels (>=1).
REQ-002: Parameter PRESCALE_BITS, default 10, width of the shared prescaler; tick period is 2**PRESCALE_BITS clk cycles.
REQ-003: Parameter COUNT_BITS, default 8, width of each channel's timeout counter.
REQ-004: Parameter EXPIRED_ON_RESET, default 1, value loaded into every expired bit at reset.
REQ-005: clk  input  1  sole clock; all state updates on posedge clk.
REQ-006: reset_n  input  1  asynchronous, active-low reset.
REQ-007: kick  input  CHANNELS  per-channel synchronous restart, level-sampled each cycle.
REQ-008: enable  input  CHANNELS  per-channel count enable; low freezes that channel.
REQ-009: timeout  input  CHANNELS*COUNT_BITS  per-channel reload value; channel i uses bits [i*COUNT_BITS +: COUNT_BITS].
REQ-010: expired  output  CHANNELS  per-channel steady-high expiry flag, registered.
REQ-011: expire_pulse  output  CHANNELS  one-cycle pulse on each 0->1 transition of expired, registered.
REQ-012: any_expired  output  1  combinational OR of all expired bits.

Function
REQ-013: The prescaler SHALL be a free-running PRESCALE_BITS counter incrementing every cycle and wrapping from all-ones to 0.
REQ-014: tick SHALL be high exactly in cycles where the prescaler register equals all-ones, and SHALL be shared by all channels.
REQ-015: Each channel SHALL hold a COUNT_BITS down-counter cnt[i] and an expired[i] register.
REQ-016: kick[i]=1 SHALL load cnt[i] <= timeout[i] and clear expired[i] <= 0 at the next edge, regardless of enable[i] or tick.
REQ-017: Kick SHALL take priority over a simultaneous tick; no decrement occurs in a kick cycle.
REQ-018: With kick[i]=0, tick=1, enable[i]=1, expired[i]=0 and cnt[i]>1, cnt[i] SHALL decrement by 1.
REQ-019: With kick[i]=0, tick=1, enable[i]=1, expired[i]=0 and cnt[i]<=1, cnt[i] SHALL become 0 and expired[i] SHALL become 1.
REQ-020: Consequence: timeout T>=1 expires on the T-th tick after the kick, and timeout 0 expires on the 1st tick.
REQ-021: Once set, expired[i] SHALL remain high until kick[i] or reset; cnt[i] SHALL hold at 0 and never wrap.
REQ-022: enable[i]=0 SHALL freeze cnt[i] and expired[i]; kick still acts.
REQ-023: expire_pulse[i] SHALL be 1 in exactly the cycle where expired[i] first reads 1 after reading 0, and 0 otherwise.
REQ-024: Re-expiry after a kick SHALL produce a new pulse.
REQ-025: Kick and expiry-setting events in the same cycle SHALL resolve to the kick (expired[i]=0, no pulse).
REQ-026: timeout[i] SHALL be sampled only in kick cycles; later changes have no effect until the next kick.
REQ-027: Channels SHALL be fully independent except for the shared prescaler.

Reset
REQ-028: reset_n=0 SHALL asynchronously force prescaler=0, all cnt=0, expired=all EXPIRED_ON_RESET, and expire_pulse=0.
REQ-029: A reset-induced expired=1 SHALL NOT generate expire_pulse.
REQ-030: Reset asserted mid-count SHALL abandon the count; after release, each channel requires a kick to restart.
REQ-031: Prescaler counting SHALL begin on the first posedge after reset_n deasserts; the first tick occurs 2**PRESCALE_BITS-1 edges later.

Verification (CHANNELS=2, PRESCALE_BITS=2, COUNT_BITS=4; tick every 4 cycles)
REQ-032: Reset with EXPIRED_ON_RESET=1 -> expired=2'b11, any_expired=1, expire_pulse=0; reset with EXPIRED_ON_RESET=0 -> expired=2'b00.
REQ-033: Kick ch0 with timeout=3 and enable=1 in a non-tick cycle -> expired[0] rises the cycle after the 3rd following tick, expire_pulse[0] is high that single cycle, and ch1 is unaffected.
REQ-034: Kick ch0 with timeout=5, then re-kick every 12 cycles for 100 cycles -> expired[0] never rises; stop kicking -> it expires 5 ticks after the last kick.
REQ-035: timeout=0 kick, with kick held high on a tick cycle -> no expiry while kick is high; after release, expiry on the first tick; kick on the exact tick cycle that would expire -> expired stays 0.
REQ-036: Drop enable[1] for 20 cycles mid-count with timeout=4 -> expiry is delayed by the number of ticks masked; raise enable and change timeout without a kick -> the original count completes.
REQ-037: Assert reset_n low asynchronously (between edges) mid-count -> outputs take reset values immediately; after release, no expiry occurs without a kick when EXPIRED_ON_RESET=0.
